// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache with one 32-bit word per line.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_controller #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] TAG_CHECK = 3'd1;
  localparam logic [2:0] WRITEBACK = 3'd2;
  localparam logic [2:0] FILL_REQ  = 3'd3;
  localparam logic [2:0] FILL_WAIT = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             we_q;
  logic [31:0]      addr_q, wdata_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic [TAG_W-1:0] tag_mem [LINES];
  logic [31:0]      data_mem [LINES];
  logic [LINES-1:0] valid_vec, dirty_vec;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic [TAG_W-1:0]      line_tag;
  logic [31:0]           line_data;
  logic                  hit, victim_dirty, fill, wr_hit;

  assign idx          = addr_q[INDEX_BITS-1:0];
  assign tag          = addr_q[31:INDEX_BITS];
  assign line_tag     = tag_mem[idx];
  assign line_data    = data_mem[idx];
  assign hit          = valid_vec[idx] && (line_tag == tag);
  assign victim_dirty = valid_vec[idx] && dirty_vec[idx];
  assign fill         = (state_q == FILL_WAIT);
  assign wr_hit       = (state_q == TAG_CHECK) && hit && we_q;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE:      if (cpu_req) state_d = TAG_CHECK;
      TAG_CHECK: begin
        if (hit) begin
          state_d = IDLE;
          ready_d = 1'b1;
          if (!we_q) rdata_d = line_data;
        end else if (victim_dirty) begin
          state_d = WRITEBACK;
        end else begin
          state_d = FILL_REQ;
        end
      end
      WRITEBACK: state_d = FILL_REQ;
      FILL_REQ:  state_d = FILL_WAIT;
      FILL_WAIT: state_d = TAG_CHECK;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      if (state_q == IDLE && cpu_req) begin
        we_q    <= cpu_we;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
      end
    end
  end

  // Tag/data storage is never reset; only the valid/dirty bits qualify it.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= mem_rdata;
    end else if (wr_hit) begin
      data_mem[idx] <= wdata_q;
    end
  end

  genvar gi;
  for (gi = 0; gi < LINES; gi++) begin : g_line
    logic valid_q, dirty_q, sel;
    assign sel = (idx == INDEX_BITS'(gi));
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        dirty_q <= 1'b0;
      end else if (sel && fill) begin
        valid_q <= 1'b1;
        dirty_q <= 1'b0;
      end else if (sel && wr_hit) begin
        dirty_q <= 1'b1;
      end
    end
    assign valid_vec[gi] = valid_q;
    assign dirty_vec[gi] = dirty_q;
  end

  // Memory strobes decode straight from state so reset silences them at once.
  always_comb begin
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_memwrite = 1'b0;
    mem_memread  = 1'b0;
    if (state_q == WRITEBACK) begin
      mem_memwrite = 1'b1;
      mem_addr     = {line_tag, idx};
      mem_wdata    = line_data;
    end else if (state_q == FILL_REQ) begin
      mem_memread = 1'b1;
      mem_addr    = addr_q;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign cpu_busy  = (state_q != IDLE);

`ifdef CACHE_STATS_EN
  logic        first_q;
  logic [15:0] hit_q, miss_q;

  // first_q marks the initial tag check of a request; the post-fill re-check is skipped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      if (state_q == IDLE && cpu_req) first_q <= 1'b1;
      else if (state_q == TAG_CHECK)  first_q <= 1'b0;
      if (state_q == TAG_CHECK && first_q) begin
        if (hit) begin
          if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
        end else begin
          if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
        end
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: expected CPU responses and memory
// strobes are queued by the stimulus and checked by a negedge monitor.
module tb_cache_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready, cpu_busy;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_memwrite, mem_memread;
  logic [31:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cache_controller #(.INDEX_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    bit          chk_gap;
    string       name;
  } resp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } memop_t;

  resp_t  resp_q[$];
  memop_t mem_q[$];
  int     acc_q[$];
  int     cyc = 0;
  int     last_ready_cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  logic [31:0] memory [256];

  always @(posedge clk) cyc++;

  // Main-memory model: data returned the cycle after the read strobe is sampled.
  always @(posedge clk) begin
    if (mem_memread)  mem_rdata <= memory[mem_addr[7:0]];
    if (mem_memwrite) memory[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: accepts, completions and memory strobes.
  always @(negedge clk) begin
    if (rst) begin
      acc_q.delete();
    end else begin
      if (!cpu_busy && cpu_req) acc_q.push_back(cyc + 1);
      if (cpu_ready) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          resp_t r;
          int    lat;
          r = resp_q.pop_front();
          lat = (acc_q.size() > 0) ? (cyc - acc_q.pop_front() + 1) : -1;
          chk({r.name, "_rdata"}, cpu_rdata, r.rdata);
          chk({r.name, "_latency"}, 32'(lat), 32'(r.lat));
          if (r.chk_gap) chk({r.name, "_gap"}, 32'(cyc - last_ready_cyc), 32'd2);
          $display("resp %-10s rdata=0x%08h latency=%0d", r.name, cpu_rdata, lat);
        end
        last_ready_cyc = cyc;
      end
      if (mem_memread && mem_memwrite) begin
        chk("strobes_both_high", 32'd1, 32'd0);
      end else if (mem_memread || mem_memwrite) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_strobe", mem_addr, 32'hFFFF_FFFF);
        end else begin
          memop_t m;
          m = mem_q.pop_front();
          chk("mem_is_write", 32'(mem_memwrite), 32'(m.wr));
          chk("mem_addr", mem_addr, m.addr);
          if (m.wr) chk("mem_wdata", mem_wdata, m.data);
          $display("mem  %s addr=0x%08h wdata=0x%08h", mem_memwrite ? "WR" : "RD", mem_addr, mem_wdata);
        end
      end else if (!cpu_busy) begin
        chk("idle_mem_addr", mem_addr, 32'd0);
        chk("idle_mem_wdata", mem_wdata, 32'd0);
      end
    end
  end

  task automatic wait_busy(input logic lvl, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (cpu_busy == lvl) ok = 1'b1;
    end
    chk({name, "_handshake"}, 32'(ok), 32'd1);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input int exp_lat, input string name);
    resp_t r;
    r.rdata = exp_rdata; r.lat = exp_lat; r.chk_gap = 1'b0; r.name = name;
    resp_q.push_back(r);
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    wait_busy(1'b1, name);
    cpu_req = 1'b0;
    wait_busy(1'b0, name);
  endtask

  task automatic exp_mem(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    memop_t m;
    m.wr = wr; m.addr = addr; m.data = data;
    mem_q.push_back(m);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) memory[i] = 32'(i);
    #1;
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_busy", 32'(cpu_busy), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_strobes", {30'd0, mem_memread, mem_memwrite}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    exp_mem(1'b0, 32'h05, '0);
    issue(1'b0, 32'h05, '0, 32'h5, 5, "rd05_miss");
    issue(1'b0, 32'h05, '0, 32'h5, 2, "rd05_hit");
`ifdef CACHE_STATS_EN
    chk("hit_count", 32'(hit_count), 32'd1);
    chk("miss_count", 32'(miss_count), 32'd1);
`endif
    exp_mem(1'b0, 32'h15, '0);
    issue(1'b1, 32'h15, 32'hDEADBEEF, 32'h5, 5, "wr15_miss");
    exp_mem(1'b1, 32'h15, 32'hDEADBEEF);
    exp_mem(1'b0, 32'h05, '0);
    issue(1'b0, 32'h05, '0, 32'h5, 6, "rd05_dirty");
    exp_mem(1'b0, 32'h15, '0);
    issue(1'b0, 32'h15, '0, 32'hDEADBEEF, 5, "rd15_wb");
    exp_mem(1'b0, 32'h03, '0);
    issue(1'b0, 32'h03, '0, 32'h3, 5, "rd03_miss");

    // Back-to-back hits with cpu_req held high throughout.
    for (int k = 0; k < 6; k++) begin
      resp_t r;
      r.rdata = (k % 2 == 0) ? 32'h3 : 32'hDEADBEEF;
      r.lat = 2; r.chk_gap = (k != 0); r.name = $sformatf("b2b_%0d", k);
      resp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h03;
    for (int k = 0; k < 6; k++) begin
      wait_busy(1'b1, "b2b");
      if (k < 5) cpu_addr = (k % 2 == 0) ? 32'h15 : 32'h03;
      else cpu_req = 1'b0;
    end
    wait_busy(1'b0, "b2b_end");

    // Reset during FILL_WAIT of a read miss: the request is abandoned.
    exp_mem(1'b0, 32'h25, '0);
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h25;
    wait_busy(1'b1, "rd25_abort");
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(cpu_busy), 32'd0);
    chk("midrst_ready", 32'(cpu_ready), 32'd0);
    chk("midrst_rdata", cpu_rdata, 32'd0);
    chk("midrst_mem_strobes", {30'd0, mem_memread, mem_memwrite}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
`ifdef CACHE_STATS_EN
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);
`endif
    exp_mem(1'b0, 32'h03, '0);
    issue(1'b0, 32'h03, '0, 32'h3, 5, "rd03_postrst");
    exp_mem(1'b0, 32'h25, '0);
    issue(1'b0, 32'h25, '0, 32'h25, 5, "rd25_retry");

    repeat (5) @(posedge clk);
    #1;
    chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
